secure_dp_packetizer: RTL and testbench

- Upstream neighbour of block_a. Drives block_a's secure_data_plane_in interface.
- Accepts a raw word stream on a valid/ready port and buffers it in a small FIFO.
- Cuts the stream into packets whose length is set over a simple control-plane register port.
- Emits each packet downstream with SOP/EOP framing, followed by one XOR checksum beat.

---
 rtl/secure_dp_packetizer_pkg.sv | 26 ++
 rtl/secure_dp_sync_fifo.sv | 69 ++++++
 rtl/secure_dp_packetizer.sv | 201 ++++++++++++++++++++
 tb/tb_secure_dp_packetizer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_dp_packetizer_pkg.sv
// Shared types and helpers for the secure data-plane packetizer.
// Holds the FSM state encoding, default sizes and the length clamp.
package secure_dp_packetizer_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_MAX_LEN = 16;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CSUM,
        DONE
    } state_e;

    // Zero-length packets make no sense, so they become single-word packets.
    function automatic int clampLen(input int len, input int maxLen);
        if (len < 1) begin
            return 1;
        end
        if (len > maxLen) begin
            return maxLen;
        end
        return len;
    endfunction

endpackage

// File: rtl/secure_dp_sync_fifo.sv
// Small synchronous FIFO buffering raw input words ahead of the packetizer.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module secure_dp_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              doPush;
    logic              doPop;

    assign full_o    = (count_q == (ADDR_W + 1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign doPush    = push_i && !full_o;
    assign doPop     = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (doPush) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (doPop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/secure_dp_packetizer.sv
// Cuts a buffered word stream into SOP-framed packets, each closed by an
// XOR checksum beat carrying EOP, feeding block_a's secure data-plane input.
module secure_dp_packetizer
    import secure_dp_packetizer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_is_csum,
    output logic              busy,
    output logic [15:0]       pkt_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPop;
    logic [DATA_W-1:0] fifoHead;
    logic [CNT_W-1:0]  fifoCount;
    logic              unusedFifoCount;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cfg_len_q;
    logic              cfg_enable_q;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              out_is_csum_q, out_is_csum_d;
    logic [15:0]       pkt_count_q, pkt_count_d;

    logic              loadOk;
    logic              beatAccepted;
    logic              startPkt;
    logic              takeWord;
    logic [LEN_W-1:0]  beatNext;

    secure_dp_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (in_valid),
        .push_data_i (in_data),
        .pop_i       (fifoPop),
        .rd_data_o   (fifoHead),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty),
        .count_o     (fifoCount)
    );

    assign unusedFifoCount = ^fifoCount;

    assign loadOk       = !out_valid_q || out_ready;
    assign beatAccepted = out_valid_q && out_ready;
    assign beatNext     = beat_cnt_q + ONE_LEN;
    assign startPkt     = (state_q == IDLE) && cfg_enable_q && !fifoEmpty && loadOk;
    assign takeWord     = (state_q == PAYLOAD) && !fifoEmpty && loadOk;

    // Config writes only touch the staging register; packets read it at start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_len_q    <= ONE_LEN;
            cfg_enable_q <= 1'b0;
        end else if (cfg_wr) begin
            cfg_len_q    <= LEN_W'(clampLen(int'(cfg_len), MAX_LEN));
            cfg_enable_q <= cfg_enable;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startPkt) state_d = (cfg_len_q == ONE_LEN) ? CSUM : PAYLOAD;
            PAYLOAD: if (takeWord && (beatNext == len_q)) state_d = CSUM;
            CSUM:    if (loadOk) state_d = DONE;
            DONE:    if (beatAccepted) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An accepted beat empties the output register unless a new beat loads.
    always_comb begin
        fifoPop       = 1'b0;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        csum_d        = csum_q;
        out_valid_d   = beatAccepted ? 1'b0 : out_valid_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_is_csum_d = out_is_csum_q;
        pkt_count_d   = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (startPkt) begin
                    fifoPop       = 1'b1;
                    len_d         = cfg_len_q;
                    beat_cnt_d    = ONE_LEN;
                    csum_d        = fifoHead;
                    out_valid_d   = 1'b1;
                    out_data_d    = fifoHead;
                    out_sop_d     = 1'b1;
                    out_eop_d     = 1'b0;
                    out_is_csum_d = 1'b0;
                end
            end
            PAYLOAD: begin
                if (takeWord) begin
                    fifoPop       = 1'b1;
                    beat_cnt_d    = beatNext;
                    csum_d        = csum_q ^ fifoHead;
                    out_valid_d   = 1'b1;
                    out_data_d    = fifoHead;
                    out_sop_d     = 1'b0;
                    out_eop_d     = 1'b0;
                    out_is_csum_d = 1'b0;
                end
            end
            CSUM: begin
                if (loadOk) begin
                    out_valid_d   = 1'b1;
                    out_data_d    = csum_q;
                    out_sop_d     = 1'b0;
                    out_eop_d     = 1'b1;
                    out_is_csum_d = 1'b1;
                end
            end
            DONE: begin
                if (beatAccepted) begin
                    pkt_count_d = pkt_count_q + 16'd1;
                    csum_d      = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q         <= ONE_LEN;
            beat_cnt_q    <= '0;
            csum_q        <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_is_csum_q <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            csum_q        <= csum_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_is_csum_q <= out_is_csum_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign in_ready    = !fifoFull;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_is_csum = out_is_csum_q;
    assign busy        = (state_q != IDLE);
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_secure_dp_packetizer.sv
// Directed plus randomized bench for secure_dp_packetizer; a packet-level
// model turns accepted words and configured lengths into expected beats.
module tb_secure_dp_packetizer;

    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_wr = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              cfg_enable = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_is_csum;
    logic              busy;
    logic [15:0]       pkt_count;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       isCsum;
    } beat_t;

    beat_t      expQ[$];
    beat_t      obsQ[$];
    logic [7:0] modelWords[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         expPkts = 0;
    beat_t      stallBeat;
    logic       stalled = 1'b0;

    secure_dp_packetizer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (8),
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_wr      (cfg_wr),
        .cfg_len     (cfg_len),
        .cfg_enable  (cfg_enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_is_csum (out_is_csum),
        .busy        (busy),
        .pkt_count   (pkt_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Records accepted beats and checks that a stalled beat is held unchanged.
    always @(negedge clock) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stallValid", 32'(out_valid), 32'd1);
                check("stallHold", 32'({out_data, out_sop, out_eop, out_is_csum}), 32'(stallBeat));
            end
            if (out_valid && out_ready) begin
                obsQ.push_back(beat_t'{data: out_data, sop: out_sop, eop: out_eop, isCsum: out_is_csum});
            end
            stalled   = out_valid && !out_ready;
            stallBeat = beat_t'{data: out_data, sop: out_sop, eop: out_eop, isCsum: out_is_csum};
        end
    end

    function automatic int modelLen(input int l);
        if (l == 0) return 1;
        if (l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    // One packet: the next L buffered words, then their XOR as the EOP beat.
    task automatic modelPacket(input int len);
        int         l = modelLen(len);
        logic [7:0] x = 8'h00;
        logic [7:0] w;
        for (int i = 0; i < l; i++) begin
            w = modelWords.pop_front();
            x ^= w;
            expQ.push_back(beat_t'{data: w, sop: (i == 0), eop: 1'b0, isCsum: 1'b0});
        end
        expQ.push_back(beat_t'{data: x, sop: 1'b0, eop: 1'b1, isCsum: 1'b1});
        expPkts++;
    endtask

    task automatic cfgWrite(input int len, input logic en);
        cfg_wr     = 1'b1;
        cfg_len    = LEN_W'(len);
        cfg_enable = en;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("pushAccepted", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        modelWords.push_back(w);
    endtask

    task automatic waitBeats(input int n, input int budget);
        int c = 0;
        while (obsQ.size() < n && c < budget) begin
            tick();
            c++;
        end
        check("beatsArrived", 32'(obsQ.size()), 32'(n));
    endtask

    task automatic checkOutput(input string tag);
        int n;
        waitBeats(expQ.size(), 600);
        tick();
        check({tag, " beatCount"}, 32'(obsQ.size()), 32'(expQ.size()));
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s beat%0d", tag, i), 32'(obsQ[i]), 32'(expQ[i]));
        end
        check({tag, " pktCount"}, 32'(pkt_count), 32'(expPkts[15:0]));
        obsQ.delete();
        expQ.delete();
    endtask

    initial begin
        logic [7:0] words[24];
        int         cyc;
        int         idx;
        logic       acc;
        logic       sawLow;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("resetOutputs", 32'({out_valid, out_data, out_sop, out_eop, out_is_csum, busy, pkt_count}), 32'd0);
        check("resetInReady", 32'(in_ready), 32'd1);

        // Single packet with first-beat latency
        cfgWrite(4, 1'b1);
        applyStimulus(8'h11);
        check("latencyEdgeN", 32'(out_valid), 32'd0);
        applyStimulus(8'h22);
        check("latencyEdgeN1", 32'({out_valid, out_sop, out_data}), 32'({1'b1, 1'b1, 8'h11}));
        check("busyInPacket", 32'(busy), 32'd1);
        applyStimulus(8'h44);
        applyStimulus(8'h88);
        modelPacket(4);
        checkOutput("single");
        check("singleCsum", 32'(8'h11 ^ 8'h22 ^ 8'h44 ^ 8'h88), 32'(8'hFF));
        check("busyAfter", 32'(busy), 32'd0);

        // Length zero clamps to one word per packet
        cfgWrite(0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) modelPacket(0);
        checkOutput("clampZero");

        // Oversized length clamps to MAX_LEN
        cfgWrite(31, 1'b1);
        for (int i = 0; i < 16; i++) applyStimulus(8'($urandom_range(0, 255)));
        modelPacket(31);
        checkOutput("clampMax");

        // Backpressure: out_ready toggles while 24 words stream in
        cfgWrite(8, 1'b1);
        for (int i = 0; i < 24; i++) words[i] = 8'($urandom_range(0, 255));
        idx    = 0;
        cyc    = 0;
        sawLow = 1'b0;
        while ((idx < 24 || obsQ.size() < 27) && cyc < 2000) begin
            out_ready = cyc[0];
            in_valid  = (idx < 24);
            in_data   = (idx < 24) ? words[idx] : 8'h00;
            if (!in_ready) sawLow = 1'b1;
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                modelWords.push_back(words[idx]);
                idx++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) modelPacket(8);
        checkOutput("backpressure");
        check("sawInReadyLow", 32'(sawLow), 32'd1);

        // Length rewritten mid-packet only affects the next packet
        cfgWrite(4, 1'b1);
        applyStimulus(8'($urandom_range(0, 255)));
        applyStimulus(8'($urandom_range(0, 255)));
        waitBeats(2, 100);
        cfgWrite(2, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom_range(0, 255)));
        modelPacket(4);
        modelPacket(2);
        checkOutput("cfgChange");

        // Disabled: words buffer, nothing is emitted
        cfgWrite(3, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) begin
            check("disabledQuiet", 32'(out_valid), 32'd0);
            tick();
        end
        cfgWrite(5, 1'b1);
        check("enableEdge", 32'(out_valid), 32'd0);
        tick();
        check("enablePlus1", 32'({out_valid, out_sop}), 32'd3);
        modelPacket(5);
        checkOutput("enable");

        // FIFO full blocks further pushes
        cfgWrite(1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(8'($urandom_range(0, 255)));
        check("fullInReady", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        in_valid = 1'b0;
        cfgWrite(4, 1'b1);
        modelPacket(4);
        modelPacket(4);
        checkOutput("fullDrain");

        // Reset mid-packet drops the partial packet
        cfgWrite(4, 1'b1);
        applyStimulus(8'($urandom_range(0, 255)));
        applyStimulus(8'($urandom_range(0, 255)));
        waitBeats(2, 100);
        reset = 1'b1;
        #1;
        check("midResetOutputs", 32'({out_valid, out_data, out_sop, out_eop, out_is_csum, busy, pkt_count}), 32'd0);
        check("midResetInReady", 32'(in_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        obsQ.delete();
        expQ.delete();
        modelWords.delete();
        expPkts = 0;
        check("postResetCount", 32'(pkt_count), 32'd0);
        applyStimulus(8'($urandom_range(0, 255)));
        tick();
        tick();
        check("postResetDisabled", 32'(out_valid), 32'd0);
        cfgWrite(4, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(0, 255)));
        modelPacket(4);
        checkOutput("afterReset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
